mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port round-robin arbiter that shares one single-port 16x8 memory (sync-write, registered-address read, 1-cycle read latency) between requesters A and B.
- Sits directly in front of the memory block.
- Grants at most one access per clock, drives the memory's adr/dat_w/we and returns read data to the requester that issued the read.

Parameters:
- ADR_W, 4, memory address width
- DAT_W, 8, memory data width

Ports:
- clk  input  1  single system clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset, sampled on rising clk
- a_valid  input  1  requester A has an access pending
- a_ready  output  1  A's access is accepted this cycle
- a_we  input  1  1 = write, 0 = read
- a_adr  input  ADR_W  A address
- a_dat_w  input  DAT_W  A write data
- a_resp_valid  output  1  A read data valid (one-cycle pulse)
- a_resp_dat  output  DAT_W  A read data
- b_valid, b_ready, b_we, b_adr, b_dat_w, b_resp_valid, b_resp_dat  same as A, for requester B
- mem_adr  output  ADR_W  memory address (read and write)
- mem_dat_w  output  DAT_W  memory write data
- mem_we  output  1  memory write enable
- mem_dat_r  input  DAT_W  memory read data, valid the cycle after the address is presented

Behaviour:
- Grant (combinational from current inputs and the prio register):
  - only one valid asserted -> that requester wins;
  - both asserted -> requester selected by prio wins (prio=0 selects A, prio=1 selects B).
- Handshake: x_ready = win_x & ~rst. Transfer occurs when x_valid & x_ready. Requesters hold valid/we/adr/dat_w stable until ready. ready never asserts without valid.
- Memory drive:
  - mem_adr / mem_dat_w = winner's adr / dat_w;
  - mem_we = transfer & winner's we.
  - With no winner: mem_adr=0, mem_dat_w=0, mem_we=0.
- prio register:
  - on a transfer, prio <= ~(winner==B), i.e. the loser gets priority next;
  - holds when idle;
  - reset value 0 (A first).
- Read pipeline:
  - Stage 1: on a read transfer in cycle N, register rd_pend=1 and rd_owner.
  - Stage 2: in cycle N+1, capture mem_dat_r into owner's resp_dat register and set owner's resp_valid. Both are visible in cycle N+2.
  - Read latency from accepted request to resp_valid = 2 cycles.
  - Fully pipelined: a new access may be accepted every cycle, including N+1.
- Response outputs:
  - resp_valid is a one-cycle pulse; no back-pressure on responses.
  - resp_dat holds its last value until overwritten.
- Write: completes at the accept edge; no response pulse.
- Ordering:
  - A write in N+1 to the address read in N does not disturb the read result; data is captured from mem_dat_r during N+1.
  - A read in N+1 after a write in N returns the new data.
- Reset values: a_ready=b_ready=0 while rst high; mem_we=0 while rst high; a/b_resp_valid=0; a/b_resp_dat=0; prio=0; rd_pend=0.
- Reset mid-operation: a read accepted in the cycle before rst asserts has its response dropped (no resp_valid after reset). A transfer cannot occur in a cycle where rst is high.
- Simultaneous requests to the same address from A and B: serialized by priority; the loser is served next cycle and sees the winner's write, if any.

Optional Feature:
- Macro MEMARB_STATS_EN.
- When defined:
  - adds outputs a_grant_cnt and b_grant_cnt (16 bits each);
  - each counts accepted transfers, saturating at 16'hFFFF;
  - both cleared by rst.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then A writes adr=3 dat=8'h5A (cycle 0), then A reads adr=3 -> a_ready=1 each cycle, mem_we=1 only in cycle 0, a_resp_valid pulses 2 cycles after the read accept with a_resp_dat=8'h5A; b_resp_valid stays 0.
- A and B both valid, reads to adr=1 and adr=2, held for 4 cycles -> grants alternate A,B,A,B; each resp_valid pulses on the correct port with its own address's data.
- Back-to-back: A read adr=7 (value 8'h11) in cycle N, B write adr=7 dat=8'h22 in cycle N+1, A read adr=7 in N+2 -> first A response 8'h11, second A response 8'h22.
- Assert rst for one cycle, the cycle after an accepted B read -> no b_resp_valid afterwards; prio=0, so with both valid next, A wins first.
- Only B valid for 3 cycles, then both valid -> A wins (prio moved to A after B's transfers); no idle cycles between accepts.
- With MEMARB_STATS_EN: 5 A transfers and 3 B transfers -> a_grant_cnt=5, b_grant_cnt=3; rst clears both to 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between requesters A and B.
// Optional MEMARB_STATS_EN adds saturating per-port accepted-transfer counters.
module mem_arbiter #(
   parameter int ADR_W = 4,
   parameter int DAT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
`ifdef MEMARB_STATS_EN
   output logic [15:0]      a_grant_cnt,
   output logic [15:0]      b_grant_cnt,
`endif
   input  logic             a_valid,
   output logic             a_ready,
   input  logic             a_we,
   input  logic [ADR_W-1:0] a_adr,
   input  logic [DAT_W-1:0] a_dat_w,
   output logic             a_resp_valid,
   output logic [DAT_W-1:0] a_resp_dat,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic             b_we,
   input  logic [ADR_W-1:0] b_adr,
   input  logic [DAT_W-1:0] b_dat_w,
   output logic             b_resp_valid,
   output logic [DAT_W-1:0] b_resp_dat,
   output logic [ADR_W-1:0] mem_adr,
   output logic [DAT_W-1:0] mem_dat_w,
   output logic             mem_we,
   input  logic [DAT_W-1:0] mem_dat_r
);

   typedef struct packed {
      logic             we;
      logic [ADR_W-1:0] adr;
      logic [DAT_W-1:0] dat;
   } req_t;

   logic prio;      // 0: A wins a tie, 1: B wins a tie
   logic win_a, win_b, xfer_a, xfer_b, xfer;
   logic rd_pend, rd_owner;
   req_t sel;

   assign win_a  = a_valid & (~b_valid | ~prio);
   assign win_b  = b_valid & (~a_valid | prio);
   assign xfer_a = win_a & ~rst;
   assign xfer_b = win_b & ~rst;
   assign xfer   = xfer_a | xfer_b;

   assign a_ready = xfer_a;
   assign b_ready = xfer_b;

   always_comb begin
      sel = '0;
      if (win_a)      sel = '{we: a_we, adr: a_adr, dat: a_dat_w};
      else if (win_b) sel = '{we: b_we, adr: b_adr, dat: b_dat_w};
   end

   assign mem_adr   = sel.adr;
   assign mem_dat_w = sel.dat;
   assign mem_we    = xfer & sel.we;

   always_ff @(posedge clk) begin
      if (rst) begin
         prio     <= 1'b0;
         rd_pend  <= 1'b0;
         rd_owner <= 1'b0;
      end else begin
         if (xfer) prio <= ~xfer_b;
         rd_pend  <= xfer & ~sel.we;
         rd_owner <= xfer_b;
      end
   end

   // Read data is sampled in the cycle after accept, before any write in that cycle lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_resp_valid <= 1'b0;
         b_resp_valid <= 1'b0;
         a_resp_dat   <= '0;
         b_resp_dat   <= '0;
      end else begin
         a_resp_valid <= rd_pend & ~rd_owner;
         b_resp_valid <= rd_pend & rd_owner;
         if (rd_pend & ~rd_owner) a_resp_dat <= mem_dat_r;
         if (rd_pend & rd_owner)  b_resp_dat <= mem_dat_r;
      end
   end

`ifdef MEMARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         a_grant_cnt <= '0;
         b_grant_cnt <= '0;
      end else begin
         if (xfer_a && a_grant_cnt != 16'hFFFF) a_grant_cnt <= a_grant_cnt + 16'd1;
         if (xfer_b && b_grant_cnt != 16'hFFFF) b_grant_cnt <= b_grant_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (shadow memory, response queues, tie-break flag).
module tb_mem_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_ready, b_ready, a_resp_valid, b_resp_valid, mem_we;
   logic [7:0] a_resp_dat, b_resp_dat, mem_dat_w, mem_dat_r;
   logic [3:0] mem_adr;
`ifdef MEMARB_STATS_EN
   logic [15:0] a_grant_cnt, b_grant_cnt;
`endif

   typedef struct packed {
      logic       valid;
      logic       we;
      logic [3:0] adr;
      logic [7:0] dat;
   } req_t;
   typedef struct {
      int         due;
      logic [7:0] dat;
   } rsp_t;

   req_t ra = '0, rb = '0;
   req_t qa[$], qb[$];
   rsp_t aq[$], bq[$];
   logic [7:0] a_obs[$];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
`ifdef MEMARB_STATS_EN
      .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt),
`endif
      .a_valid(ra.valid), .a_ready(a_ready), .a_we(ra.we), .a_adr(ra.adr),
      .a_dat_w(ra.dat), .a_resp_valid(a_resp_valid), .a_resp_dat(a_resp_dat),
      .b_valid(rb.valid), .b_ready(b_ready), .b_we(rb.we), .b_adr(rb.adr),
      .b_dat_w(rb.dat), .b_resp_valid(b_resp_valid), .b_resp_dat(b_resp_dat),
      .mem_adr(mem_adr), .mem_dat_w(mem_dat_w), .mem_we(mem_we), .mem_dat_r(mem_dat_r)
   );

   // The memory the arbiter fronts: sync write, registered read address.
   logic [7:0] tmem [16];
   logic [3:0] rd_adr;
   assign mem_dat_r = tmem[rd_adr];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) tmem[i] <= 8'(i * 19 + 7);
      end else if (mem_we) tmem[mem_adr] <= mem_dat_w;
      rd_adr <= mem_adr;
   end

   // Reference model state
   int         ncmp = 0, nerr = 0, cyc = 0;
   logic       m_prio = 1'b0;
   logic [7:0] shadow [16];
   logic [7:0] m_a_dat = 8'h0, m_b_dat = 8'h0;
   int         m_a_cnt = 0, m_b_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic cycle();
      bit wa, wb, xa, xb, eav, ebv;
      req_t w;
      ra = (qa.size() > 0) ? qa[0] : '0;
      rb = (qb.size() > 0) ? qb[0] : '0;
      @(negedge clk);
      wa = ra.valid && (!rb.valid || !m_prio);
      wb = rb.valid && (!ra.valid || m_prio);
      xa = wa && !rst;
      xb = wb && !rst;
      w  = wa ? ra : (wb ? rb : '0);
      chk("a_ready", a_ready, xa);
      chk("b_ready", b_ready, xb);
      chk("mem_we", mem_we, (xa || xb) && w.we);
      chk("mem_adr", mem_adr, w.adr);
      chk("mem_dat_w", mem_dat_w, w.dat);
      eav = aq.size() > 0 && aq[0].due == cyc;
      ebv = bq.size() > 0 && bq[0].due == cyc;
      chk("a_resp_valid", a_resp_valid, eav);
      chk("b_resp_valid", b_resp_valid, ebv);
      if (eav) m_a_dat = aq.pop_front().dat;
      if (ebv) m_b_dat = bq.pop_front().dat;
      chk("a_resp_dat", a_resp_dat, m_a_dat);
      chk("b_resp_dat", b_resp_dat, m_b_dat);
      if (a_resp_valid === 1'b1) a_obs.push_back(a_resp_dat);
`ifdef MEMARB_STATS_EN
      chk("a_grant_cnt", a_grant_cnt, m_a_cnt);
      chk("b_grant_cnt", b_grant_cnt, m_b_cnt);
`endif
      if (rst) begin
         m_prio = 1'b0;
         aq.delete(); bq.delete();
         m_a_dat = 8'h0; m_b_dat = 8'h0;
         m_a_cnt = 0; m_b_cnt = 0;
         for (int i = 0; i < 16; i++) shadow[i] = 8'(i * 19 + 7);
      end else if (xa || xb) begin
         m_prio = !xb;   // loser gets the next tie
         if (w.we) shadow[w.adr] = w.dat;
         else if (xa) aq.push_back('{cyc + 2, shadow[w.adr]});
         else         bq.push_back('{cyc + 2, shadow[w.adr]});
         if (xa) begin void'(qa.pop_front()); if (m_a_cnt < 16'hFFFF) m_a_cnt++; end
         else    begin void'(qb.pop_front()); if (m_b_cnt < 16'hFFFF) m_b_cnt++; end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((qa.size() || qb.size() || aq.size() || bq.size()) && n < limit) begin
         cycle();
         n++;
      end
      chk("drain_timeout", n < limit, 1);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) cycle();
      rst = 1'b0;
   endtask

   function automatic req_t rq(input logic we, input logic [3:0] adr, input logic [7:0] dat);
      return '{1'b1, we, adr, dat};
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) shadow[i] = 8'(i * 19 + 7);
      #1;
      do_reset(2);

      // Write then read back on A
      qa.push_back(rq(1, 3, 8'h5A));
      qa.push_back(rq(0, 3, 8'h00));
      drain(20);
      chk("t1_resp", a_obs.size() > 0 ? a_obs[a_obs.size()-1] : 8'hxx, 8'h5A);

      // Contending reads alternate grants
      do_reset(1);
      repeat (2) begin qa.push_back(rq(0, 1, 8'h0)); qb.push_back(rq(0, 2, 8'h0)); end
      drain(20);

      // Write between two reads of the same address
      qb.push_back(rq(1, 7, 8'h11));
      drain(20);
      a_obs.delete();
      qa.push_back(rq(0, 7, 8'h0));
      qa.push_back(rq(0, 7, 8'h0));
      qb.push_back(rq(1, 7, 8'h22));
      drain(20);
      chk("t3_n_resp", a_obs.size(), 2);
      if (a_obs.size() == 2) begin
         chk("t3_first", a_obs[0], 8'h11);
         chk("t3_second", a_obs[1], 8'h22);
      end

      // Reset right after an accepted B read drops its response
      qb.push_back(rq(0, 5, 8'h0));
      cycle();
      do_reset(1);
      repeat (3) cycle();
      qa.push_back(rq(0, 4, 8'h0));
      qb.push_back(rq(0, 6, 8'h0));
      drain(20);

      // B alone for three cycles, then both: A wins
      repeat (3) qb.push_back(rq(0, 9, 8'h0));
      repeat (3) cycle();
      qa.push_back(rq(0, 10, 8'h0));
      qb.push_back(rq(1, 10, 8'h77));
      drain(20);

`ifdef MEMARB_STATS_EN
      do_reset(1);
      repeat (5) qa.push_back(rq(1, 2, 8'h33));
      repeat (3) qb.push_back(rq(0, 2, 8'h0));
      drain(30);
      chk("cnt_a5", a_grant_cnt, 5);
      chk("cnt_b3", b_grant_cnt, 3);
      do_reset(1);
      chk("cnt_a_rst", a_grant_cnt, 0);
      chk("cnt_b_rst", b_grant_cnt, 0);
`endif

      // Random traffic, with occasional resets
      for (int k = 0; k < 600; k++) begin
         if (qa.size() == 0 && $urandom_range(0, 2) != 0)
            qa.push_back(rq(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom)));
         if (qb.size() == 0 && $urandom_range(0, 2) != 0)
            qb.push_back(rq(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom)));
         rst = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0;
      drain(50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
